conv_frame_sequencer: RTL and testbench

Frame-level scheduler that feeds the convolver's sample-load interface from an external column stream. It accepts 16-bit sample columns over a valid/ready handshake and presents them on `col_out` as single-cycle `sample_load_en` pulses, gated by the convolver controller's `modwait`. It also tracks column and row position to raise `new_row` on the first column of every row, and signals frame completion. It sits between a DMA or test source and the convolver's sample inputs; it drives the same signals the AHB slave otherwise drives.

---
 rtl/conv_seq_pkg.sv | 16 +
 rtl/flex_counter.sv | 31 +++
 rtl/conv_frame_sequencer.sv | 134 +++++++++++++
 tb/tb_conv_frame_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and constants for the convolver frame sequencer
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_COL = 3'd1,
        LOAD     = 3'd2,
        HOLD     = 3'd3,
        DRAIN    = 3'd4
    } seq_state_t;

    localparam int MIN_WIDTH  = 3;
    localparam int MIN_HEIGHT = 1;
    localparam int COL_W      = 16;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - wrapping up-counter with programmable rollover value
module flex_counter #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag
);

    // Flag marks the terminal count, so the next enabled step wraps to zero.
    assign rollover_flag = (count_out == rollover_val);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (rollover_flag) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + NUM_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - feeds convolver sample loads from a column stream, tracking row/frame position
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH_BITS-1:0]  img_width,
    input  logic [HEIGHT_BITS-1:0] img_height,
    input  logic                   col_valid,
    input  logic [COL_W-1:0]       col_data,
    output logic                   col_ready,
    input  logic                   modwait,
    output logic [COL_W-1:0]       col_out,
    output logic                   sample_load_en,
    output logic                   new_row,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err,
    output logic [15:0]            frame_results
);

    seq_state_t state_q, state_d;

    logic [WIDTH_BITS-1:0]  width_q;
    logic [HEIGHT_BITS-1:0] height_q;
    logic [WIDTH_BITS-1:0]  col_cnt;
    logic [HEIGHT_BITS-1:0] row_cnt_unused;
    logic                   col_last, row_last, is_last_q;
    logic                   geom_ok, start_ok, handshake, done_set;
    logic [WIDTH_BITS-1:0]  width_m2;
    logic [15:0]            result_prod;

    assign geom_ok  = (img_width >= WIDTH_BITS'(MIN_WIDTH)) &&
                      (img_height >= HEIGHT_BITS'(MIN_HEIGHT));
    assign start_ok = (state_q == IDLE) && start && geom_ok;

    // Abort wins over a same-cycle handshake, so the column stays with the source.
    assign col_ready      = (state_q == WAIT_COL) && !modwait && !abort;
    assign handshake      = col_ready && col_valid;
    assign sample_load_en = (state_q == LOAD);
    assign new_row        = sample_load_en && (col_cnt == '0);
    assign busy           = (state_q != IDLE);

    assign width_m2    = img_width - WIDTH_BITS'(2);
    assign result_prod = 16'(width_m2) * 16'(img_height);

    flex_counter #(.NUM_BITS(WIDTH_BITS)) u_col_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (start_ok),
        .count_enable (sample_load_en),
        .rollover_val (width_q - WIDTH_BITS'(1)),
        .count_out    (col_cnt),
        .rollover_flag(col_last)
    );

    flex_counter #(.NUM_BITS(HEIGHT_BITS)) u_row_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (start_ok),
        .count_enable (sample_load_en && col_last),
        .rollover_val (height_q - HEIGHT_BITS'(1)),
        .count_out    (row_cnt_unused),
        .rollover_flag(row_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        case (state_q)
            IDLE:     if (start_ok) state_d = WAIT_COL;
            WAIT_COL: begin
                if (abort)          state_d = IDLE;
                else if (handshake) state_d = LOAD;
            end
            LOAD:     state_d = abort ? IDLE : HOLD;
            HOLD: begin
                if (abort)          state_d = IDLE;
                else if (is_last_q) state_d = DRAIN;
                else                state_d = WAIT_COL;
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!modwait) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_out       <= '0;
            width_q       <= '0;
            height_q      <= '0;
            frame_results <= '0;
            is_last_q     <= 1'b0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            frame_done <= done_set;
            err        <= (state_q == IDLE) && start && !geom_ok;
            if (start_ok) begin
                width_q       <= img_width;
                height_q      <= img_height;
                frame_results <= result_prod;
            end
            if (handshake) begin
                col_out <= col_data;
            end
            // Counters hold the position of the column being loaded during LOAD.
            if (sample_load_en) begin
                is_last_q <= col_last && row_last;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - directed self-checking bench for conv_frame_sequencer
module tb_conv_frame_sequencer;

    logic        clk = 1'b0;
    logic        n_rst, start, abort, col_valid, modwait;
    logic [7:0]  img_width, img_height;
    logic [15:0] col_data;
    logic        col_ready, sample_load_en, new_row, busy, frame_done, err;
    logic [15:0] col_out, frame_results;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          loads, dones, gap_err, order_err, prot_err;
    logic [31:0] nr_mask;
    int          hs, src;
    logic        flag;

    conv_frame_sequencer #(.WIDTH_BITS(8), .HEIGHT_BITS(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .abort         (abort),
        .img_width     (img_width),
        .img_height    (img_height),
        .col_valid     (col_valid),
        .col_data      (col_data),
        .col_ready     (col_ready),
        .modwait       (modwait),
        .col_out       (col_out),
        .sample_load_en(sample_load_en),
        .new_row       (new_row),
        .busy          (busy),
        .frame_done    (frame_done),
        .err           (err),
        .frame_results (frame_results)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams columns 1,2,3... and records load spacing, new_row positions and protocol slips.
    task automatic run_frame(input int w, input int h, input int mw_len, input int exp_gap);
        int   s, exp_col, mw_cnt, last_load;
        logic fin;
        loads = 0; dones = 0; nr_mask = '0; gap_err = 0; order_err = 0; prot_err = 0;
        s = 1; exp_col = 1; mw_cnt = 0; last_load = -1; fin = 1'b0;
        img_width  = w[7:0];
        img_height = h[7:0];
        modwait    = 1'b0;
        col_valid  = 1'b1;
        col_data   = 16'(s);
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            modwait  = (mw_cnt > 0);
            col_data = 16'(s);
            #1;
            if (modwait && (col_ready || sample_load_en)) prot_err++;
            if (new_row && !sample_load_en) prot_err++;
            if (sample_load_en) begin
                if (col_out != 16'(exp_col)) order_err++;
                exp_col++;
                if (loads < 32) nr_mask[loads] = new_row;
                if (last_load >= 0 && (cyc - last_load) != exp_gap) gap_err++;
                last_load = cyc;
                loads++;
            end
            if (frame_done) begin
                dones++;
                fin = 1'b1;
            end
            if (col_ready && col_valid) s++;
            if (sample_load_en) mw_cnt = mw_len;
            else if (mw_cnt > 0) mw_cnt--;
            step();
        end
        modwait   = 1'b0;
        col_valid = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; col_valid = 1'b0; modwait = 1'b0;
        img_width = '0; img_height = '0; col_data = '0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_load", sample_load_en, 0);
        check("rst_col_out", col_out, 0);
        check("rst_ready", col_ready, 0);
        check("rst_results", frame_results, 0);
        check("rst_err", err, 0);
        check("rst_done", frame_done, 0);
        n_rst = 1'b1;
        step();

        // Nominal 4x2 frame, no back-pressure
        run_frame(4, 2, 0, 3);
        check("nom_loads", loads, 8);
        check("nom_gap", gap_err, 0);
        check("nom_new_row", nr_mask, 32'h11);
        check("nom_order", order_err, 0);
        check("nom_protocol", prot_err, 0);
        check("nom_done", dones, 1);
        check("nom_results", frame_results, 4);
        check("nom_busy_after", busy, 0);
        check("nom_done_once", frame_done, 0);

        // Back-pressure: modwait held 5 cycles after each load, 3x2 frame
        run_frame(3, 2, 5, 7);
        check("bp_loads", loads, 6);
        check("bp_gap", gap_err, 0);
        check("bp_new_row", nr_mask, 32'h9);
        check("bp_order", order_err, 0);
        check("bp_protocol", prot_err, 0);
        check("bp_done", dones, 1);
        check("bp_results", frame_results, 2);

        // Illegal geometry: width too small, then zero height
        img_width = 8'd2; img_height = 8'd3; start = 1'b1; col_valid = 1'b1;
        step();
        start = 1'b0;
        check("ill1_err", err, 1);
        check("ill1_busy", busy, 0);
        check("ill1_ready", col_ready, 0);
        step();
        check("ill1_err_pulse", err, 0);
        check("ill1_results", frame_results, 2);
        img_width = 8'd5; img_height = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("ill2_err", err, 1);
        check("ill2_busy", busy, 0);
        check("ill2_ready", col_ready, 0);
        step();
        check("ill2_err_pulse", err, 0);
        check("ill2_results", frame_results, 2);
        col_valid = 1'b0;

        // Abort on the 3rd handshake of a 6x2 frame
        img_width = 8'd6; img_height = 8'd2; start = 1'b1; col_valid = 1'b1;
        src = 1; col_data = 16'd1;
        step();
        start = 1'b0;
        hs = 0; flag = 1'b0;
        for (int c = 0; c < 60 && !flag; c++) begin
            col_data = 16'(src);
            #1;
            if (col_ready) begin
                hs++;
                if (hs == 3) begin
                    abort = 1'b1;
                    #1;
                    check("abort_ready_low", col_ready, 0);
                    flag = 1'b1;
                end else begin
                    src++;
                end
            end
            step();
        end
        check("abort_reached", flag, 1);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_load", sample_load_en, 0);
        check("abort_new_row", new_row, 0);
        check("abort_ready", col_ready, 0);
        check("abort_col_out", col_out, 16'h0002);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (frame_done) dones++;
            step();
        end
        check("abort_no_done", dones, 0);
        check("abort_idle", busy, 0);
        col_valid = 1'b0;

        run_frame(6, 2, 0, 3);
        check("post_abort_loads", loads, 12);
        check("post_abort_new_row", nr_mask, 32'h41);
        check("post_abort_order", order_err, 0);
        check("post_abort_done", dones, 1);
        check("post_abort_results", frame_results, 8);

        // Reset asserted while LOAD is active
        img_width = 8'd4; img_height = 8'd1; start = 1'b1; col_valid = 1'b1; col_data = 16'h00AB;
        step();
        start = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 20 && !flag; c++) begin
            #1;
            if (sample_load_en) flag = 1'b1;
            else step();
        end
        check("rstload_reached", flag, 1);
        check("rstload_col_out_pre", col_out, 16'h00AB);
        n_rst = 1'b0;
        #1;
        check("rstload_load", sample_load_en, 0);
        check("rstload_busy", busy, 0);
        check("rstload_col_out", col_out, 0);
        check("rstload_results", frame_results, 0);
        col_valid = 1'b0;
        step();
        n_rst = 1'b1;
        step();

        // Largest geometry: 253 * 255
        img_width = 8'd255; img_height = 8'd255; start = 1'b1;
        step();
        start = 1'b0;
        check("ovf_results", frame_results, 64515);
        check("ovf_busy", busy, 1);
        check("ovf_err", err, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ovf_abort_idle", busy, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
